// File: rtl/systolic_feed_scheduler_pkg.sv
// Shared definitions for the systolic array feed path: scheduler state
// encoding and the width helpers that the scheduler, array top and FIFO bank must agree on.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

  // Step counter must hold len + ROWS - 2 without wrapping.
  function automatic int step_width(input int rows, input int len_width);
    return len_width + $clog2(rows) + 1;
  endfunction

  // Occupancy counter width for a FIFO of the given depth (0..depth inclusive).
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/systolic_feed_scheduler.sv
// Read-side sequencer for the west-edge row FIFOs: drains len elements per row
// in a diagonal wavefront, stalling all rows together when any due row is empty.
module systolic_feed_scheduler
  import systolic_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int LEN_WIDTH = 8,
  parameter int STEP_W    = step_width(ROWS, LEN_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [ROWS-1:0]      fifo_empty,
  output logic [ROWS-1:0]      fifo_r_en,
  output logic                 step,
  output logic [ROWS-1:0]      row_active,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          stall_count
);

  sched_state_t         state, state_nx;
  logic [STEP_W-1:0]    t;
  logic [LEN_WIDTH-1:0] len_q;
  logic [STEP_W-1:0]    len_ext;
  logic [STEP_W-1:0]    last_t;
  logic [ROWS-1:0]      win;
  logic                 in_run;
  logic                 stall;
  logic                 last_step;
  logic                 accept;

  always_comb begin
    len_ext = STEP_W'(len_q);
    last_t  = len_ext + STEP_W'(ROWS) - STEP_W'(2);
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_win
    localparam logic [STEP_W-1:0] ROW_IDX = STEP_W'(r);
    assign win[r] = (t >= ROW_IDX) && (t < ROW_IDX + len_ext);
  end

  // Reset gates the read path combinationally so no FIFO pops on the reset edge.
  always_comb begin
    in_run     = (state == ST_RUN) && !rst_n;
    stall      = in_run && (|(win & fifo_empty));
    step       = in_run && !stall;
    fifo_r_en  = step ? win : '0;
    row_active = fifo_r_en;
    busy       = (state == ST_RUN);
    done       = (state == ST_DONE);
    last_step  = step && (t == last_t);
    accept     = start && (len != '0);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN:  if (last_step) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= ST_IDLE;
      t           <= '0;
      len_q       <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && accept) begin
        len_q       <= len;
        t           <= '0;
        stall_count <= '0;
      end
      if (step && !last_step)
        t <= t + STEP_W'(1);
      if (stall && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Scoreboard bench for systolic_feed_scheduler: per-step expected row masks are
// queued at start and popped as the DUT steps, against a simple FIFO-bank model.
module tb_systolic_feed_scheduler;
  localparam int ROWS = 4;
  localparam int LW   = 8;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [LW-1:0]   len_i;
  logic [ROWS-1:0] fifo_empty;
  logic [ROWS-1:0] fifo_r_en;
  logic            step;
  logic [ROWS-1:0] row_active;
  logic            busy;
  logic            done;
  logic [15:0]     stall_count;

  int              total;
  int              bad;
  logic [ROWS-1:0] exp_q[$];
  int              pops[ROWS];
  int              base[ROWS];
  int              fill;
  logic [ROWS-1:0] force_e;

  systolic_feed_scheduler #(.ROWS(ROWS), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len_i),
    .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en), .step(step),
    .row_active(row_active), .busy(busy), .done(done), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int r = 0; r < ROWS; r++) pops[r] = 0;
  always @(posedge clk)
    for (int r = 0; r < ROWS; r++)
      if (fifo_r_en[r]) pops[r] <= pops[r] + 1;

  always_comb begin
    fifo_empty = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      fifo_empty[r] = force_e[r] || ((pops[r] - base[r]) >= fill);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One tile: optional forced-empty window on one row, optional stray start, optional reset.
  task automatic run_tile(input int l, input int frow, input int ffrom, input int fto,
                          input int exp_done, input int exp_stall,
                          input int mid_c, input int rst_c);
    int c, done_c, ndone;
    bit fin;
    logic [ROWS-1:0] e;
    for (int r = 0; r < ROWS; r++) base[r] = pops[r];
    fill = l;
    for (int s = 0; s < l + ROWS - 1; s++) begin
      e = '0;
      for (int r = 0; r < ROWS; r++) if (s >= r && s < r + l) e[r] = 1'b1;
      exp_q.push_back(e);
    end
    start = 1'b1;
    len_i = LW'(l);
    @(posedge clk); #1;
    start = 1'b0;
    len_i = LW'($urandom);
    c = 1; done_c = -1; ndone = 0; fin = 1'b0;
    while (!fin) begin
      force_e = '0;
      if (c >= ffrom && c <= fto) force_e[frow] = 1'b1;
      if (c == mid_c) begin start = 1'b1; len_i = 8'd5; end
      if (c == rst_c) rst_n = 1'b1;
      @(negedge clk);
      if (c == rst_c) begin
        check_eq("rst_cycle_ren", fifo_r_en, '0);
      end else if (c == rst_c + 1) begin
        check_eq("post_rst_ren", fifo_r_en, '0);
        check_eq("post_rst_act", row_active, '0);
        check_eq("post_rst_step", step, 0);
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_done", done, 0);
        check_eq("post_rst_stall", stall_count, 0);
        exp_q.delete();
        fin = 1'b1;
      end else begin
        if (step) begin
          if (exp_q.size() == 0) check_eq("extra_step", step, 0);
          else begin
            e = exp_q.pop_front();
            check_eq("ren", fifo_r_en, e);
            check_eq("row_active", row_active, e);
          end
        end else begin
          check_eq("nostep_ren", fifo_r_en, '0);
        end
        if (c == 1) check_eq("busy_run", busy, 1);
        if (done) begin ndone++; done_c = c; end
        if (done_c > 0 && c == done_c + 1) fin = 1'b1;
        if (c > exp_done + 20) begin
          check_eq("done_timeout", done_c, exp_done);
          fin = 1'b1;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      rst_n = 1'b0;
      c++;
    end
    force_e = '0;
    if (rst_c < 0) begin
      check_eq("done_cycle", done_c, exp_done);
      check_eq("done_pulses", ndone, 1);
      check_eq("stall_count", stall_count, exp_stall);
      check_eq("busy_after", busy, 0);
      check_eq("queue_left", exp_q.size(), 0);
      for (int r = 0; r < ROWS; r++) check_eq("pops_row", pops[r] - base[r], l);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b1; start = 1'b0; len_i = '0; force_e = '0; fill = 0;
    for (int r = 0; r < ROWS; r++) base[r] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ren", fifo_r_en, '0);
    check_eq("reset_act", row_active, '0);
    check_eq("reset_step", step, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_stall", stall_count, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;

    run_tile(3, 0, -10, -10, 7, 0, -10, -10);
    run_tile(3, 2, 3, 5, 10, 3, -10, -10);

    // len==0 start must be ignored
    for (int r = 0; r < ROWS; r++) base[r] = pops[r];
    fill = 100;
    start = 1'b1; len_i = '0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("len0_busy", busy, 0);
      check_eq("len0_ren", fifo_r_en, '0);
      check_eq("len0_done", done, 0);
      @(posedge clk); #1;
    end

    run_tile(3, 0, -10, -10, 7, 0, 2, -10);
    run_tile(255, 0, -10, -10, 259, 0, -10, -10);
    run_tile(3, 0, -10, -10, 7, 0, -10, 3);
    run_tile(2, 0, -10, -10, 6, 0, -10, -10);
    run_tile(1, 0, 1, 70000, 70005, 16'hFFFF, -10, -10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
